// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and width constants for the hole-in-the-wall
//                game control blocks (phase encoding, tick/round widths,
//                zero-to-one helper for programmable periods).
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Phase encoding is visible on the phase_out port; values are fixed.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        ACTIVE    = 3'd2,
        EVAL      = 3'd3,
        SCORE     = 3'd4,
        DONE      = 3'd5
    } phase_t;

    localparam int TICK_W_DEFAULT = 16;
    localparam int ROUND_W        = 8;

    // A programmed period of 0 behaves exactly like 1.
    function automatic logic [31:0] nonzero32(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Programmable-period wrap counter producing a registered
//                1-cycle tick. The tick is high in the cycle whose count is
//                period-1, i.e. the cycle at whose end the count wraps to 0.
//                enable/clear describe the *next* cycle, so the registered
//                tick can already be valid in the first counting cycle.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                clear  - next cycle starts a fresh interval (count = 0)
//                enable - next cycle is a counting cycle; else count held 0
//                period - clocks per tick (0 treated as 1)
//                tick   - registered tick pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] r_count;
    logic        r_tick;
    logic [31:0] w_last;
    logic [31:0] w_count_inc;

    always_comb begin
        w_last      = nonzero32(period) - 32'd1;
        // >= rather than == keeps the counter sane if the period shrinks
        w_count_inc = (r_count >= w_last) ? 32'd0 : r_count + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 32'd0;
            r_tick  <= 1'b0;
        end else if (!enable) begin
            r_count <= 32'd0;
            r_tick  <= 1'b0;
        end else if (clear) begin
            r_count <= 32'd0;
            r_tick  <= (w_last == 32'd0);
        end else begin
            r_count <= w_count_inc;
            r_tick  <= (w_count_inc == w_last);
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/round_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : round_phase_scheduler
//  Description : Game-round sequencer. Steps each round through COUNTDOWN,
//                ACTIVE, EVAL and SCORE with tick-based durations, hands off
//                to the pose evaluator through eval_req_out/eval_ack_in, and
//                finishes in DONE after NUM_ROUNDS rounds.
//  Config macro: DIFFICULTY_RAMP_EN - shrinks ACTIVE by RAMP_STEP_TICKS per
//                round, floored at MIN_ACTIVE_TICKS.
//  Ports       : clk_in/rst_in (async active-low), start_in, abort_in,
//                cycles_per_tick_in, countdown/active/score_ticks_in,
//                eval_ack_in -> phase_out, phase_start_out, tick_out,
//                ticks_remaining_out, round_out, eval_req_out, game_over_out
//  Revision    : 1.0 - initial release
// ============================================================================
module round_phase_scheduler
    import game_pkg::*;
#(
    parameter int NUM_ROUNDS       = 5,
    parameter int TICK_W           = TICK_W_DEFAULT,
    parameter int RAMP_STEP_TICKS  = 100,
    parameter int MIN_ACTIVE_TICKS = 500
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [31:0]       cycles_per_tick_in,
    input  logic [TICK_W-1:0] countdown_ticks_in,
    input  logic [TICK_W-1:0] active_ticks_in,
    input  logic [TICK_W-1:0] score_ticks_in,
    input  logic              eval_ack_in,
    output logic [2:0]        phase_out,
    output logic              phase_start_out,
    output logic              tick_out,
    output logic [TICK_W-1:0] ticks_remaining_out,
    output logic [7:0]        round_out,
    output logic              eval_req_out,
    output logic              game_over_out
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 255) begin : g_bad_num_rounds
        $error("NUM_ROUNDS must be within 1..255");
    end
    if (RAMP_STEP_TICKS < 0 || MIN_ACTIVE_TICKS < 0) begin : g_bad_ramp
        $error("ramp parameters must be non-negative");
    end

    function automatic logic [TICK_W-1:0] nonzero_ticks(input logic [TICK_W-1:0] value);
        return (value == '0) ? TICK_W'(1) : value;
    endfunction

    phase_t              r_phase;
    phase_t              w_next_phase;
    logic [TICK_W-1:0]   r_remaining;
    logic [TICK_W-1:0]   w_next_remaining;
    logic [ROUND_W-1:0]  r_round;
    logic [ROUND_W-1:0]  w_next_round;
    logic                r_phase_start;
    logic                r_eval_req;
    logic                r_game_over;

    // Configuration captured when a game is started
    logic [31:0]         r_period;
    logic [TICK_W-1:0]   r_countdown;
    logic [TICK_W-1:0]   r_active;
    logic [TICK_W-1:0]   r_score;

    logic                w_accept;
    logic                w_tick;
    logic                w_last_tick;
    logic                w_next_timed;
    logic [31:0]         w_period_sel;
    logic [TICK_W-1:0]   w_active_dur;

    assign w_accept    = start_in && !abort_in && (r_phase == IDLE || r_phase == DONE);
    assign w_last_tick = w_tick && (r_remaining <= TICK_W'(1));

    // The prescaler decides its first-cycle tick at the start edge, before the
    // latched period is visible, so it sees the incoming value on that edge.
    assign w_period_sel = w_accept ? cycles_per_tick_in : r_period;

`ifdef DIFFICULTY_RAMP_EN
    logic [47:0] w_ramp_active;
    logic [47:0] w_ramp_floor;
    logic [47:0] w_ramp_cut;

    // Compared before subtracting so the reduction can never wrap below zero.
    always_comb begin
        w_ramp_active = 48'(r_active);
        w_ramp_floor  = 48'(MIN_ACTIVE_TICKS);
        w_ramp_cut    = 48'(r_round) * 48'(RAMP_STEP_TICKS);
        if (w_ramp_active <= w_ramp_floor) begin
            w_active_dur = r_active;
        end else if (w_ramp_cut >= w_ramp_active - w_ramp_floor) begin
            w_active_dur = nonzero_ticks(TICK_W'(w_ramp_floor));
        end else begin
            w_active_dur = TICK_W'(w_ramp_active - w_ramp_cut);
        end
    end
`else
    assign w_active_dur = r_active;
`endif

    always_comb begin
        w_next_phase     = r_phase;
        w_next_remaining = r_remaining;
        w_next_round     = r_round;

        if (abort_in) begin
            w_next_phase     = IDLE;
            w_next_remaining = '0;
            w_next_round     = '0;
        end else begin
            case (r_phase)
                IDLE, DONE: begin
                    if (start_in) begin
                        w_next_phase     = COUNTDOWN;
                        w_next_remaining = nonzero_ticks(countdown_ticks_in);
                        w_next_round     = '0;
                    end
                end
                COUNTDOWN: begin
                    if (w_last_tick) begin
                        w_next_phase     = ACTIVE;
                        w_next_remaining = w_active_dur;
                    end else if (w_tick) begin
                        w_next_remaining = r_remaining - TICK_W'(1);
                    end
                end
                ACTIVE: begin
                    if (w_last_tick) begin
                        w_next_phase     = EVAL;
                        w_next_remaining = '0;
                    end else if (w_tick) begin
                        w_next_remaining = r_remaining - TICK_W'(1);
                    end
                end
                EVAL: begin
                    if (eval_ack_in) begin
                        w_next_phase     = SCORE;
                        w_next_remaining = r_score;
                    end
                end
                SCORE: begin
                    if (w_last_tick) begin
                        if (r_round == ROUND_W'(NUM_ROUNDS - 1)) begin
                            w_next_phase     = DONE;
                            w_next_remaining = '0;
                        end else begin
                            w_next_phase     = COUNTDOWN;
                            w_next_remaining = r_countdown;
                            w_next_round     = r_round + ROUND_W'(1);
                        end
                    end else if (w_tick) begin
                        w_next_remaining = r_remaining - TICK_W'(1);
                    end
                end
                default: begin
                    w_next_phase     = IDLE;
                    w_next_remaining = '0;
                    w_next_round     = '0;
                end
            endcase
        end
    end

    assign w_next_timed = (w_next_phase == COUNTDOWN) || (w_next_phase == ACTIVE) ||
                          (w_next_phase == SCORE);

    // Every phase change restarts the interval so a D-tick phase is D*P cycles.
    tick_prescaler u_prescaler (
        .clk    (clk_in),
        .rst_n  (rst_in),
        .clear  (w_next_phase != r_phase),
        .enable (w_next_timed),
        .period (w_period_sel),
        .tick   (w_tick)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_phase       <= IDLE;
            r_remaining   <= '0;
            r_round       <= '0;
            r_phase_start <= 1'b0;
            r_eval_req    <= 1'b0;
            r_game_over   <= 1'b0;
            r_period      <= 32'd1;
            r_countdown   <= TICK_W'(1);
            r_active      <= TICK_W'(1);
            r_score       <= TICK_W'(1);
        end else begin
            r_phase       <= w_next_phase;
            r_remaining   <= w_next_remaining;
            r_round       <= w_next_round;
            r_phase_start <= (w_next_phase != r_phase) && (w_next_phase != IDLE);
            r_eval_req    <= (w_next_phase == EVAL);
            r_game_over   <= (w_next_phase == DONE);
            if (w_accept) begin
                r_period    <= nonzero32(cycles_per_tick_in);
                r_countdown <= nonzero_ticks(countdown_ticks_in);
                r_active    <= nonzero_ticks(active_ticks_in);
                r_score     <= nonzero_ticks(score_ticks_in);
            end
        end
    end

    assign phase_out           = r_phase;
    assign phase_start_out     = r_phase_start;
    assign tick_out            = w_tick;
    assign ticks_remaining_out = r_remaining;
    assign round_out           = r_round;
    assign eval_req_out        = r_eval_req;
    assign game_over_out       = r_game_over;

endmodule
`default_nettype wire

// File: doc/round_phase_scheduler.md
Name: round_phase_scheduler

Overview:
Game-round sequencer for the hole-in-the-wall top level. Derives a tick from the system clock using a programmable-period prescaler, the same style as the dynamic-max event counter. Steps each round through COUNTDOWN, ACTIVE, EVAL and SCORE phases with programmable tick durations, and hands off to the pose evaluator via a req/ack handshake. Drives phase, remaining-time and round outputs for the display and game logic.

Parameters:
NUM_ROUNDS, 5, rounds per game (1..255)
TICK_W, 16, width of phase duration and remaining-tick values
RAMP_STEP_TICKS, 100, ACTIVE-duration reduction per round (optional feature only)
MIN_ACTIVE_TICKS, 500, floor on ramped ACTIVE duration (optional feature only)

Ports:
clk_in  input  1  system clock; only clock
rst_in  input  1  reset, asynchronous, active-low
start_in  input  1  start game; honoured in IDLE and DONE only
abort_in  input  1  return to IDLE; highest priority
cycles_per_tick_in  input  32  prescaler period in clocks
countdown_ticks_in  input  TICK_W  COUNTDOWN duration in ticks
active_ticks_in  input  TICK_W  ACTIVE duration in ticks
score_ticks_in  input  TICK_W  SCORE duration in ticks
eval_ack_in  input  1  evaluator done; sampled in EVAL only
phase_out  output  3  current phase (package enum)
phase_start_out  output  1  1-cycle pulse, first cycle of each non-IDLE phase
tick_out  output  1  1-cycle prescaler pulse
ticks_remaining_out  output  TICK_W  ticks left in current timed phase
round_out  output  8  zero-based round index
eval_req_out  output  1  high throughout EVAL
game_over_out  output  1  high in DONE

Behaviour:
- All outputs registered. While rst_in=0: phase=IDLE, round=0, ticks_remaining=0, all pulses and flags 0, prescaler count=0.
- Config latch: on accepted start_in, latch cycles_per_tick and all three durations. Later input changes do not affect the running game.
- Zero handling: a value of 0 is treated as 1 for cycles_per_tick and for every duration.
- Prescaler:
  - Counts 0..P-1 only in COUNTDOWN, ACTIVE and SCORE. tick_out=1 in the cycle where the count wraps to 0. P=1 gives a tick every cycle.
  - Count is forced to 0 on every phase entry, so a timed phase of D ticks lasts exactly D*P cycles.
  - Count is held at 0 in IDLE, EVAL and DONE.
- Phase entry:
  - On entry to a timed phase, ticks_remaining loads D and phase_start_out pulses.
  - On each tick, ticks_remaining decrements.
  - A tick with ticks_remaining==1 leaves the phase at that edge. ticks_remaining never shows 0 inside a timed phase.
- Transitions:
  - IDLE: start_in -> COUNTDOWN, round=0.
  - COUNTDOWN: expiry -> ACTIVE.
  - ACTIVE: expiry -> EVAL.
  - EVAL: eval_req_out=1 from the first EVAL cycle. eval_ack_in=1 -> SCORE at the next edge. Ack in the first EVAL cycle is legal, so EVAL lasts a minimum of 1 cycle. No timeout.
  - SCORE: on expiry, if round==NUM_ROUNDS-1 -> DONE; otherwise round+1 and -> COUNTDOWN.
  - DONE: game_over_out=1, round holds. start_in -> COUNTDOWN with round=0 and a fresh config latch.
- Priority:
  - abort_in=1 in any state -> IDLE next edge, round=0, ticks_remaining=0, eval_req_out=0. abort_in beats start_in and expiry.
  - start_in outside IDLE/DONE is ignored.
  - eval_ack_in outside EVAL is ignored.
- Reset: async assertion mid-game clears everything immediately. Deassertion is assumed synchronised upstream.

Optional Feature:
- Macro: DIFFICULTY_RAMP_EN.
- When defined, the ACTIVE duration for round r is max(active_latched - r*RAMP_STEP_TICKS, MIN_ACTIVE_TICKS).
  - Computed with no unsigned underflow; saturates at the floor.
  - If the latched value is already below the floor, the latched value is used unchanged.
- When undefined, every round uses the latched ACTIVE duration; the RAMP parameters are unused.

Decomposition:
- Shared package game_pkg:
  - phase_t enum: IDLE=0, COUNTDOWN=1, ACTIVE=2, EVAL=3, SCORE=4, DONE=5.
  - Width constants: TICK_W default, ROUND_W=8.
- One sub-module, tick_prescaler:
  - 32-bit wrap counter with a clear input and enable; outputs the tick pulse.
  - Reused by other timed blocks.
- FSM, round counter and remaining-tick counter stay in round_phase_scheduler.

Test Plan:
- Basic round: P=4, durations 3/5/2, NUM_ROUNDS=1, ack 2 cycles after req.
  - COUNTDOWN 12 cycles, ACTIVE 20, EVAL 3, SCORE 8, then DONE with game_over_out=1.
  - tick_out every 4th cycle in timed phases.
- Zero config: P=0, all durations 0.
  - Each timed phase lasts 1 cycle with tick_out=1.
  - ticks_remaining_out=1 in each timed phase.
  - phase_start_out pulses on each entry.
- Multi-round: NUM_ROUNDS=3.
  - round_out steps 0,1,2, then DONE with round_out=2.
  - start_in in DONE restarts at COUNTDOWN with round_out=0.
- Abort mid-ACTIVE plus start same cycle: ticks_remaining=4, abort_in=1 and start_in=1 together.
  - Next cycle IDLE, ticks_remaining_out=0, prescaler cleared.
  - Changing cycles_per_tick_in mid-game has no effect on tick spacing.
- Async reset mid-EVAL: assert rst_in=0 between clock edges.
  - eval_req_out and all outputs clear before the next edge.
  - Ack with eval_ack_in=1 in the first EVAL cycle gives a 1-cycle EVAL.
- DIFFICULTY_RAMP_EN: active=700, step=100, floor=500.
  - ACTIVE lasts 700, 600, 500, 500 ticks for rounds 0-3.
  - Without the macro: 700 ticks every round.
